stage_release_agent: RTL

- Stage-side receiver for the per-stage active-high reset levels issued by the top-level sequencing controller (rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp).
- One instance sits in front of each stage (mem, pe, 3b3, 2b2, disp).
- Converts the controller's reset level into four things for the stage datapath: a held local active-low reset, a one-cycle start pulse, a completion/timeout status, and a measured run latency.
- Lets the team replace fixed time budgets with observed completion.

---
 rtl/stage_agent_pkg.sv | 14 +
 rtl/stage_sat_counter.sv | 27 ++
 rtl/stage_release_agent.sv | 112 +++++++++++
 3 files changed

// File: rtl/stage_agent_pkg.sv
// Shared FSM encoding and default counter width for the stage release agent.
package stage_agent_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/stage_sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that stops at limit.
module stage_sat_counter
  import stage_agent_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt < limit)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/stage_release_agent.sv
// Turns a controller reset level into a held local reset, a start pulse,
// done/timeout status and a measured run latency for one pipeline stage.
module stage_release_agent
  import stage_agent_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int START_DELAY = 2,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_stage,
  input  logic             stage_done,
  output logic             stage_rst_n,
  output logic             stage_start,
  output logic             active,
  output logic             ready,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(START_DELAY);
  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_lim;
  logic [CNT_W-1:0] run_cnt;
  logic             phase_clr;
  logic             phase_en;
  logic             run_en;
  logic             run_clr;

  // One counter serves both HOLD and SETTLE; it restarts on every state change.
  assign phase_lim = (state == ST_HOLD) ? HOLD_LIM : DELAY_LIM;
  assign phase_clr = (state_nxt != state);
  assign phase_en  = (state == ST_HOLD) || (state == ST_SETTLE);

  // Counting on entry into RUN makes run_cnt read 1 during the start cycle.
  assign run_en  = (state_nxt == ST_RUN);
  assign run_clr = !run_en;

  stage_sat_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (phase_clr),
    .en    (phase_en),
    .limit (phase_lim),
    .cnt   (phase_cnt)
  );

  stage_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_clr),
    .en    (run_en),
    .limit (TMO_LIM),
    .cnt   (run_cnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: begin
        if (!rst_stage && (phase_cnt >= HOLD_LIM - ONE)) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (rst_stage)                            state_nxt = ST_HOLD;
        else if (phase_cnt >= DELAY_LIM - ONE)    state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (rst_stage)                 state_nxt = ST_HOLD;
        else if (stage_done)           state_nxt = ST_DONE;
        else if (run_cnt >= TMO_LIM)   state_nxt = ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (rst_stage) state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_HOLD;
      stage_rst_n <= 1'b0;
      stage_start <= 1'b0;
      active      <= 1'b0;
      ready       <= 1'b0;
      err         <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      stage_rst_n <= (state_nxt != ST_HOLD);
      stage_start <= (state == ST_SETTLE) && (state_nxt == ST_RUN);
      active      <= (state_nxt == ST_RUN);
      ready       <= (state_nxt == ST_DONE);
      err         <= (state_nxt == ST_ERR);
      if (state_nxt == ST_HOLD) begin
        cycle_count <= '0;
      end else if ((state == ST_RUN) && (state_nxt != ST_RUN)) begin
        cycle_count <= run_cnt;
      end
    end
  end

endmodule
